// File: rtl/pixel_fetch.sv
// pixel_fetch: per-line video RAM prefetcher and pixel index emitter.
//   Fetches 16-bit words (two 8-bit CLUT indices) into a small FIFO and
//   emits one index per pixel period inside the active window.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cf, st, cm             crystal/standard/colour-mode selects (W and pixel rate)
//   new_line, hblank,      timing from video_timing
//   vblank, line_addr      word address of first word of the next line
//   mem_req/mem_addr       read request, held until mem_ack
//   mem_ack/mem_data       1-cycle ack with data ([15:8] left, [7:0] right pixel)
//   pix_valid/pix_data     pixel strobe and index (0x00 on underflow)
//   underflow/underflow_clr sticky empty-on-strobe flag and its clear
module pixel_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cf,
  input  logic          st,
  input  logic          cm,
  input  logic          new_line,
  input  logic          hblank,
  input  logic          vblank,
  input  logic [AW-1:0] line_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic          underflow,
  input  logic          underflow_clr
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [8:0]    words_left;
  logic [8:0]    base_w, line_w;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_empty;

  logic [1:0]    phase, phase_last;
  logic          byte_sel;
  logic          active, strobe;
  logic          issue, push, pop;
  logic [15:0]   head;

  assign base_w     = (cf && !st) ? 9'd192 : 9'd180;
  assign line_w     = cm ? {base_w[7:0], 1'b0} : base_w;
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rd_ptr];

  assign active     = !hblank && !vblank;
  assign strobe     = active && (phase == 2'd0);
  assign phase_last = cm ? 2'd1 : 2'd3;

  // Only one request in flight: a new one is raised only while mem_req is
  // low, and the FIFO slot it will fill is already free.
  assign issue = (state == S_FETCH) && !mem_req && (fifo_cnt < DEPTH_C) &&
                 (words_left != 9'd0) && !new_line;
  // An ack landing on a new_line cycle belongs to the old line: dropped.
  assign push  = mem_req && mem_ack && (state == S_FETCH) && !new_line;
  assign pop   = strobe && !fifo_empty && !byte_sel;

  // ---------------- fetch FSM ----------------
  always_comb begin
    state_nx = state;
    if (new_line) begin
      // An unacked request must still be completed before the next line.
      state_nx = (mem_req && !mem_ack) ? S_DRAIN : S_CHECK;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_CHECK: state_nx = vblank ? S_IDLE : S_FETCH;
        S_FETCH: if (!mem_req && (words_left == 9'd0)) state_nx = S_IDLE;
        S_DRAIN: if (mem_ack) state_nx = S_CHECK;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      addr       <= '0;
      words_left <= '0;
    end else begin
      if (mem_req && mem_ack) mem_req <= 1'b0;
      else if (issue)         mem_req <= 1'b1;
      if (issue) mem_addr <= addr;
      if ((state == S_CHECK) && !new_line && !vblank) begin
        addr       <= line_addr;
        words_left <= line_w;
      end else if (push) begin
        addr       <= addr + AW'(1);
        words_left <= words_left - 9'd1;
      end
    end
  end

  // ---------------- prefetch FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk) begin
    if (reset || new_line) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- pixel output ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 2'd0;
      byte_sel  <= 1'b1;
      pix_valid <= 1'b0;
      pix_data  <= 8'h00;
      underflow <= 1'b0;
    end else begin
      pix_valid <= strobe;
      if (!active) begin
        phase    <= 2'd0;
        byte_sel <= 1'b1;
      end else begin
        // >= so a cm switch mid-period cannot strand phase above the limit
        phase <= (phase >= phase_last) ? 2'd0 : phase + 2'd1;
        if (strobe) begin
          byte_sel <= !byte_sel;
          if (fifo_empty) pix_data <= 8'h00;
          else            pix_data <= byte_sel ? head[15:8] : head[7:0];
        end
      end
      if (strobe && fifo_empty) underflow <= 1'b1;
      else if (underflow_clr)   underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: line-by-line video timing, a memory
// responder with per-line latency, and a queue-based model of the pixel
// stream and fetch address sequence.
module tb_pixel_fetch;
  localparam int AW    = 22;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, cf, st, cm, new_line, hblank, vblank;
  logic [AW-1:0] line_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          underflow, underflow_clr;

  pixel_fetch #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cf(cf), .st(st), .cm(cm), .new_line(new_line),
    .hblank(hblank), .vblank(vblank), .line_addr(line_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // bench-side line context, read by the model
  bit line_vb, line_full, model_on, clr_en;
  int lat, mcnt;

  // one clock: advance, then answer memory and drive the random clear
  task automatic tick();
    @(posedge clk); #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end else if (mem_req) begin
      mcnt++;
      if (mcnt >= lat) begin
        mem_ack  = 1'b1;
        mem_data = 16'($urandom);
      end
    end else mcnt = 0;
    underflow_clr = clr_en && ($urandom_range(0, 499) == 0);
  endtask

  // ---------------- behavioural model + compare ----------------
  logic [15:0]   q[$];
  bit            sel = 1'b1, exp_pv = 1'b0, exp_uf = 1'b0;
  logic [7:0]    exp_pd = 8'h00;
  int            acnt = 0, k = 0, w = 0, n_stale = 0, cur_ln = -1, cur_pv = 0;
  bit            stale = 0, fetch_ok = 0, cur_full = 0, cur_vb = 0, cur_uf = 0, cur_rst = 0;
  logic [AW-1:0] base = '0, cur_first = '0, cur_last = '0;
  bit            prev_req = 0, prev_ack = 0, prev_rst = 1;
  logic [AW-1:0] prev_addr = '0;
  int            ln_reqs[32] = '{default: 0};
  int            ln_pv[32]   = '{default: 0};
  logic [AW-1:0] ln_first[32] = '{default: '0};
  logic [AW-1:0] ln_last[32]  = '{default: '0};

  always @(negedge clk) begin : model
    bit strobe, uf_set;
    int n;
    logic [AW-1:0] ea;
    if (model_on) begin
      if (reset) begin
        q.delete();
        sel = 1'b1; acnt = 0; exp_pv = 0; exp_pd = 8'h00; exp_uf = 0;
        stale = 0; fetch_ok = 0; cur_rst = 1; prev_rst = 1;
      end else begin
        if (!prev_rst && prev_req && !prev_ack) begin
          check("req_hold", 32'(mem_req), 32'd1);
          check("addr_hold", 32'(mem_addr), 32'(prev_addr));
        end
        check("pix_valid", 32'(pix_valid), 32'(exp_pv));
        if (exp_pv) check("pix_data", 32'(pix_data), 32'(exp_pd));
        check("underflow", 32'(underflow), 32'(exp_uf));
        if (pix_valid) cur_pv++;

        // pixel stream: one strobe every N active clocks, bytes high-then-low
        n      = cm ? 2 : 4;
        strobe = !hblank && !vblank && (acnt % n == 0);
        acnt   = (!hblank && !vblank) ? acnt + 1 : 0;
        uf_set = 0;
        if (strobe) begin
          if (q.size() > 0) begin
            exp_pd = sel ? q[0][15:8] : q[0][7:0];
            if (!sel) void'(q.pop_front());
          end else begin
            exp_pd = 8'h00;
            uf_set = 1;
            cur_uf = 1;
          end
          sel = !sel;
        end
        if (hblank || vblank) sel = 1'b1;
        exp_pv = strobe;
        exp_uf = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : exp_uf);

        // fetch side: words of this line arrive in address order
        if (mem_req && mem_ack) begin
          if (stale || new_line) begin
            stale = 0;
          end else begin
            check("fetch_allowed", 32'(fetch_ok), 32'd1);
            ea = base + AW'(k);
            check("req_addr", 32'(mem_addr), 32'(ea));
            if (k == 0) cur_first = mem_addr;
            cur_last = mem_addr;
            k++;
            check("word_budget", 32'(k <= w), 32'd1);
            q.push_back(mem_data);
            check("fifo_bound", 32'(q.size() <= DEPTH), 32'd1);
          end
        end

        if (new_line) begin
          if (mem_req && !mem_ack) begin
            stale = 1;
            n_stale++;
          end
          if (cur_ln >= 0) begin
            if (cur_full && !cur_vb && !cur_uf && !cur_rst) check("line_words", 32'(k), 32'(w));
            if (cur_ln < 32) begin
              ln_reqs[cur_ln]  = k;
              ln_pv[cur_ln]    = cur_pv;
              ln_first[cur_ln] = cur_first;
              ln_last[cur_ln]  = cur_last;
            end
          end
          cur_ln++;
          q.delete();
          base = line_addr; k = 0; cur_pv = 0;
          w = ((cf && !st) ? 192 : 180) * (cm ? 2 : 1);
          fetch_ok = !line_vb;
          cur_full = line_full; cur_vb = line_vb; cur_uf = 0; cur_rst = 0;
        end
        prev_rst = 0;
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  // ---------------- line generator ----------------
  task automatic run_line(input bit c, input bit s, input bit m, input bit vb, input int l,
                          input int act, input logic [AW-1:0] a,
                          input bit wait_req, input bit do_rst);
    bit rst_done = 0;
    int t = 0;
    if (wait_req) begin
      do begin tick(); t++; end while (!(mem_req && !mem_ack) && t < 80);
      check("drain_setup", 32'(mem_req && !mem_ack), 32'd1);
    end else tick();
    cf = c; st = s; cm = m; line_addr = a; lat = l;
    new_line = 1; hblank = 1; line_vb = vb;
    line_full = (act == 8 * ((c && !s) ? 192 : 180));
    tick();
    new_line = 0; vblank = vb;
    for (int i = 0; i < 38; i++) begin
      tick();
      if (reset) begin
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 0;
      end else if (do_rst && !rst_done && i >= 2 && i < 36 && mem_req) begin
        reset = 1;
        rst_done = 1;
      end
    end
    if (do_rst) check("rst_fired", 32'(rst_done), 32'd1);
    hblank = 0;
    repeat (act) tick();
    hblank = 1;
    repeat (24) tick();
  endtask

  initial begin
    bit c, s, m, vb;
    int l, act;
    reset = 1; cf = 0; st = 0; cm = 0; new_line = 0; hblank = 1; vblank = 1;
    line_addr = '0; mem_ack = 0; mem_data = '0; underflow_clr = 0;
    lat = 3; mcnt = 0; clr_en = 0;
    repeat (3) tick();
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_pix_data", 32'(pix_data), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    reset = 0;
    model_on = 1;

    run_line(1, 0, 0, 1, 3,  200, 22'h000500, 0, 0);  // 0: vblank line
    run_line(1, 0, 0, 0, 3, 1536, 22'h001000, 0, 0);  // 1: W=192, 4 clk/px
    check("l1_underflow", 32'(underflow), 32'd0);
    run_line(1, 1, 1, 0, 3, 1440, 22'h020000, 0, 0);  // 2: W=360, 2 clk/px
    check("l2_underflow", 32'(underflow), 32'd0);
    run_line(0, 0, 1, 0, 20, 300, 22'h003000, 0, 0);  // 3: slow memory
    run_line(0, 1, 0, 0, 5, 1440, 22'h002000, 1, 0);  // 4: starts with a request in flight
    check("drain_seen", 32'(n_stale), 32'd1);
    check("uf_sticky", 32'(underflow), 32'd1);
    underflow_clr = 1;
    tick();
    underflow_clr = 0;
    check("uf_cleared", 32'(underflow), 32'd0);
    run_line(1, 0, 0, 0, 3,  400, 22'h004000, 0, 1);  // 5: reset mid-fetch
    run_line(0, 0, 0, 1, 2,  300, 22'h005000, 0, 0);  // 6: vblank line
    run_line(0, 0, 0, 0, 2, 1440, 22'h3FFFFA, 0, 0);  // 7: address wrap

    clr_en = 1;
    for (int j = 8; j < 14; j++) begin
      c  = 1'($urandom); s = 1'($urandom); m = 1'($urandom);
      vb = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) l = $urandom_range(8, 25);
      else l = $urandom_range(1, m ? 3 : 7);
      if ($urandom_range(0, 1) == 0) act = 8 * ((c && !s) ? 192 : 180);
      else act = $urandom_range(100, 800);
      run_line(c, s, m, vb, l, act, AW'($urandom), 0, 0);
    end
    clr_en = 0;
    run_line(0, 0, 0, 1, 2, 50, 22'h000000, 0, 0);    // closes the last line's stats
    repeat (4) tick();

    check("l0_reqs", 32'(ln_reqs[0]), 32'd0);
    check("l0_pix", 32'(ln_pv[0]), 32'd0);
    check("l1_reqs", 32'(ln_reqs[1]), 32'd192);
    check("l1_first", 32'(ln_first[1]), 32'h1000);
    check("l1_last", 32'(ln_last[1]), 32'h10BF);
    check("l1_pix", 32'(ln_pv[1]), 32'd384);
    check("l2_reqs", 32'(ln_reqs[2]), 32'd360);
    check("l2_pix", 32'(ln_pv[2]), 32'd720);
    check("l4_first", 32'(ln_first[4]), 32'h2000);
    check("l4_reqs", 32'(ln_reqs[4]), 32'd180);
    check("l6_reqs", 32'(ln_reqs[6]), 32'd0);
    check("l6_pix", 32'(ln_pv[6]), 32'd0);
    check("l7_first", 32'(ln_first[7]), 32'h3FFFFA);
    check("l7_last", 32'(ln_last[7]), 32'h0000AD);
    check("l7_reqs", 32'(ln_reqs[7]), 32'd180);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
